// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
// Captures one retire record per core update pulse and buffers it in a
// first-word-fall-through FIFO drained through a valid/ready trace port.
// The core cannot stall. A record arriving at a full FIFO that is not popping
// in the same cycle is dropped, counted, and flagged in a sticky overflow bit.
// Every update pulse consumes a sequence number, so gaps in trace_seq_o show
// disabled or dropped retires.
module commit_trace_fifo #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       update_i,
    input  logic [XLEN-1:0]            pc_i,
    input  logic [XLEN-1:0]            instr_i,
    input  logic [4:0]                 reg_addr_i,
    input  logic [XLEN-1:0]            reg_data_i,
    input  logic                       enable_i,
    input  logic                       flush_i,
    output logic                       trace_valid_o,
    input  logic                       trace_ready_i,
    output logic [XLEN-1:0]            trace_pc_o,
    output logic [XLEN-1:0]            trace_instr_o,
    output logic [4:0]                 trace_rd_addr_o,
    output logic [XLEN-1:0]            trace_rd_data_o,
    output logic [31:0]                trace_seq_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [DROP_W-1:0]          drop_cnt_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_data;
        logic [31:0]     seq;
    } rec_t;

    // Record storage. The head is read asynchronously so the record at the
    // read pointer is on the outputs the cycle after it was written (FWFT);
    // the read address is a register, so there is no input-to-output path.
    rec_t mem [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       seq_q, seq_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;

    logic full, empty, push, pop, accept, drop;
    rec_t wr_rec;
    rec_t head_rec;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    // Flush suppresses both push and pop in its cycle.
    assign push   = update_i & enable_i & ~flush_i;
    assign pop    = ~empty & trace_ready_i & ~flush_i;
    // At full, a concurrent pop frees the slot the push needs.
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    assign wr_rec = '{pc: pc_i, instr: instr_i, rd_addr: reg_addr_i,
                      rd_data: reg_data_i, seq: seq_q};

    // Next-state for pointers, occupancy, sequence and drop bookkeeping.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        // The sequence counter tracks every retire, independent of capture.
        seq_d      = update_i ? seq_q + 32'd1 : seq_q;

        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({accept, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + DROP_W'(1);
                end
            end
        end
    end

    // State registers; reset overrides every other input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Record write at the tail; storage itself is never reset.
    always_ff @(posedge clk_i) begin
        if (accept && !rst_i) begin
            mem[wr_ptr_q] <= wr_rec;
        end
    end

    assign head_rec        = mem[rd_ptr_q];
    assign trace_valid_o   = ~empty;
    assign trace_pc_o      = head_rec.pc;
    assign trace_instr_o   = head_rec.instr;
    assign trace_rd_addr_o = head_rec.rd_addr;
    assign trace_rd_data_o = head_rec.rd_data;
    assign trace_seq_o     = head_rec.seq;
    assign count_o         = count_q;
    assign full_o          = full;
    assign empty_o         = empty;
    assign drop_cnt_o      = drop_cnt_q;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Testbench for commit_trace_fifo: directed scenarios followed by a random
// phase, all checked every cycle against a queue-based reference model.
module tb_commit_trace_fifo;

    localparam int DEPTH    = 16;
    localparam int DROP_W   = 4;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] seq;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        update_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] instr_i = '0;
    logic [4:0]  reg_addr_i = '0;
    logic [31:0] reg_data_i = '0;
    logic        enable_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        trace_ready_i = 1'b0;
    logic        trace_valid_o;
    logic [31:0] trace_pc_o, trace_instr_o, trace_rd_data_o, trace_seq_o;
    logic [4:0]  trace_rd_addr_o;
    logic [4:0]  count_o;
    logic        full_o, empty_o, overflow_o;
    logic [DROP_W-1:0] drop_cnt_o;

    commit_trace_fifo #(.XLEN(32), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .update_i(update_i), .pc_i(pc_i),
        .instr_i(instr_i), .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i),
        .enable_i(enable_i), .flush_i(flush_i), .trace_valid_o(trace_valid_o),
        .trace_ready_i(trace_ready_i), .trace_pc_o(trace_pc_o),
        .trace_instr_o(trace_instr_o), .trace_rd_addr_o(trace_rd_addr_o),
        .trace_rd_data_o(trace_rd_data_o), .trace_seq_o(trace_seq_o),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
        .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    // Reference model state
    rec_t        m_q[$];
    int unsigned m_seq;
    int          m_drop;
    bit          m_ovf;
    bit          m_known = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs with the model (state after the previous edge).
    task automatic check_outputs();
        if (m_known) begin
            check("count", 64'(count_o), 64'(m_q.size()));
            check("valid", 64'(trace_valid_o), 64'(m_q.size() != 0));
            check("empty", 64'(empty_o), 64'(m_q.size() == 0));
            check("full", 64'(full_o), 64'(m_q.size() == DEPTH));
            check("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
            check("overflow", 64'(overflow_o), 64'(m_ovf));
            if (m_q.size() != 0) begin
                check("head_pc", 64'(trace_pc_o), 64'(m_q[0].pc));
                check("head_instr", 64'(trace_instr_o), 64'(m_q[0].instr));
                check("head_rd", 64'(trace_rd_addr_o), 64'(m_q[0].rd));
                check("head_data", 64'(trace_rd_data_o), 64'(m_q[0].data));
                check("head_seq", 64'(trace_seq_o), 64'(m_q[0].seq));
            end
        end
    endtask

    // Apply the rules for one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit pop, push;
        rec_t r;
        if (rst_i) begin
            m_q.delete();
            m_seq = 0; m_drop = 0; m_ovf = 0;
            m_known = 1;
        end else if (m_known) begin
            if (flush_i) begin
                m_q.delete();
                m_drop = 0; m_ovf = 0;
            end else begin
                pop  = (m_q.size() != 0) && trace_ready_i;
                push = update_i && enable_i;
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    if (m_q.size() == DEPTH) begin
                        m_ovf = 1;
                        if (m_drop < DROP_MAX) m_drop++;
                    end else begin
                        r = '{pc: pc_i, instr: instr_i, rd: reg_addr_i, data: reg_data_i, seq: m_seq};
                        m_q.push_back(r);
                    end
                end
            end
            if (update_i) m_seq++;
        end
    endtask

    // One cycle: drive inputs, check current outputs, clock, update model.
    task automatic step(input logic u, input logic e, input logic fl,
                        input logic rdy, input logic rs, input logic [31:0] pc);
        update_i = u; enable_i = e; flush_i = fl; trace_ready_i = rdy; rst_i = rs;
        pc_i = pc; instr_i = $urandom; reg_addr_i = 5'($urandom); reg_data_i = $urandom;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(0, 1, 0, rdy, 0, 32'h0);
    endtask

    initial begin
        @(posedge clk); #1;
        // 1: three records in order, visible one cycle after capture
        step(0, 1, 0, 1, 1, 0);
        check("rst_valid", 64'(trace_valid_o), 64'd0);
        check("rst_empty", 64'(empty_o), 64'd1);
        step(1, 1, 0, 1, 0, 32'h8000_0000);
        check("t1_pc0", 64'(trace_pc_o), 64'h8000_0000);
        check("t1_seq0", 64'(trace_seq_o), 64'd0);
        step(1, 1, 0, 1, 0, 32'h8000_0004);
        check("t1_seq1", 64'(trace_seq_o), 64'd1);
        step(1, 1, 0, 1, 0, 32'h8000_0008);
        check("t1_pc2", 64'(trace_pc_o), 64'h8000_0008);
        idle(2, 1);

        // 2: overfill with sink stalled
        step(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH + 3; i++) step(1, 1, 0, 0, 0, 32'h1000 + 4 * i);
        check("t2_count", 64'(count_o), 64'(DEPTH));
        check("t2_full", 64'(full_o), 64'd1);
        check("t2_drop", 64'(drop_cnt_o), 64'd3);
        check("t2_ovf", 64'(overflow_o), 64'd1);
        idle(DEPTH, 1);
        check("t2_empty", 64'(empty_o), 64'd1);
        step(1, 1, 0, 0, 0, 32'h2000);
        check("t2_seq_next", 64'(trace_seq_o), 64'(DEPTH + 3));

        // 3: full with push and pop every cycle: no drops
        step(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, 0, 32'h3000 + 4 * i);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 0, 32'h3800 + 4 * i);
        check("t3_count", 64'(count_o), 64'(DEPTH));
        check("t3_drop", 64'(drop_cnt_o), 64'd0);
        idle(DEPTH + 2, 1);

        // 4: disabled retires leave seq gaps
        step(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 32'h4000 + 4 * i);
        step(1, 0, 0, 0, 0, 32'h4100);
        step(1, 0, 0, 0, 0, 32'h4104);
        step(1, 1, 0, 0, 0, 32'h4108);
        check("t4_count", 64'(count_o), 64'd6);
        idle(8, 1);

        // 5: flush with a same-cycle update
        step(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH + 2; i++) step(1, 1, 0, 0, 0, 32'h5000 + 4 * i);
        idle(DEPTH - 5, 1);
        check("t5_held", 64'(count_o), 64'd5);
        step(1, 1, 1, 1, 0, 32'h5800);
        check("t5_empty", 64'(empty_o), 64'd1);
        check("t5_drop", 64'(drop_cnt_o), 64'd0);
        check("t5_ovf", 64'(overflow_o), 64'd0);
        step(1, 1, 0, 0, 0, 32'h5900);
        check("t5_seq", 64'(trace_seq_o), 64'(DEPTH + 3));
        idle(2, 1);

        // 6: reset mid-drain
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 32'h6000 + 4 * i);
        step(0, 1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 1, 32'h6100);
        check("t6_valid", 64'(trace_valid_o), 64'd0);
        check("t6_count", 64'(count_o), 64'd0);
        step(1, 1, 0, 1, 0, 32'h6200);
        check("t6_seq", 64'(trace_seq_o), 64'd0);
        idle(2, 1);

        // 7: drop counter saturation
        step(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH + DROP_MAX + 4; i++) step(1, 1, 0, 0, 0, 32'h7000 + i);
        check("t7_sat", 64'(drop_cnt_o), 64'(DROP_MAX));
        step(0, 1, 1, 0, 0, 0);

        // Random phase
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < ((i / 200) % 2 == 0 ? 30 : 80)) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                 $urandom);
        end
        idle(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
